// File: rtl/seq_stim_gen.sv
// Serial stimulus generator: shifts a captured pattern out MSB-first for a
// programmed number of passes and counts the detector's z hits.
module seq_stim_gen #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             z,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] shift_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] bit_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [LEN_W-1:0] len_clamped;

    // Left-align the active window so its first bit sits in the MSB.
    function automatic logic [PAT_W-1:0] align(input logic [PAT_W-1:0] p,
                                               input logic [LEN_W-1:0] l);
        return p << (LEN_W'(PAT_W) - l);
    endfunction

    always_comb begin
        len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    end

    assign x = x_valid & shift_reg[PAT_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pat_reg   <= '0;
            shift_reg <= '0;
            len_reg   <= '0;
            bit_cnt   <= '0;
            pass_cnt  <= '0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            if (x_valid && z && hit_cnt != '1)
                hit_cnt <= hit_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                    if (start && !abort) begin
                        pat_reg   <= pattern;
                        len_reg   <= len_clamped;
                        pass_cnt  <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                        shift_reg <= align(pattern, len_clamped);
                        bit_cnt   <= len_clamped;
                        hit_cnt   <= '0;
                        busy      <= 1'b1;
                        if (len_clamped == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state   <= SEND;
                            x_valid <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (abort) begin
                        state   <= IDLE;
                        x_valid <= 1'b0;
                        busy    <= 1'b0;
                    end else if (bit_cnt == LEN_W'(1)) begin
                        if (pass_cnt > CNT_W'(1)) begin
                            // Back-to-back reload: next pass starts on the very next cycle.
                            shift_reg <= align(pat_reg, len_reg);
                            bit_cnt   <= len_reg;
                            pass_cnt  <= pass_cnt - CNT_W'(1);
                        end else begin
                            state   <= FINISH;
                            x_valid <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt - LEN_W'(1);
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    x_valid <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    x_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
